alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side initiator for the team's 16-bit combinational ALU. Accepts 16-bit instructions over a valid/ready handshake and holds a 4×16-bit register file and a Z/N flag pair. It drives the ALU operand and opcode ports from the register file, then captures the ALU result and flags back into the register file. It sits between an instruction source (bench or fetch unit) and the ALU instance, and owns all sequencing the ALU itself lacks.

## Interface
- No parameters; widths fixed (data 16, registers 4, opcode 3).
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr  in  16  instruction word (format below)
- alu_m  out  16  ALU operand M (= R[rd])
- alu_n  out  16  ALU operand N (= R[rs])
- alu_c  out  1  ALU carry-in
- alu_opc  out  3  ALU opcode
- alu_f  in  16  ALU result
- alu_zer  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- res_valid  out  1  one-cycle completion pulse
- res_data  out  16  value written (or 0 if none)
- res_skip  out  1  with res_valid: condition false, nothing written
- res_err  out  1  with res_valid: opcode 111 rejected
- flag_z, flag_n  out  1 each  architectural flags

## Operation
- Instruction fields: [15:13] opc, [12:11] rd (destination and M source), [10:9] rs (N source), [8] cin, [7:6] cond (00 always, 01 Z=1, 10 N=1, 11 Z=0), [5] ld, [4:0] imm5.
- ALU opcode meaning: 000 M+N+cin; 001 M+(N>>>1); 010 signed max(M,N); 011 3·M; 100 M&N; 101 M|N; 110 ~M; 111 invalid.
- FSM states: IDLE, EXEC, DONE.
- IDLE: instr_ready=1. Evaluate cond against current flags on handshake.
  - cond false -> DONE with res_skip=1.
  - cond true, ld=1 -> R[rd] <= sign-extended imm5; flag_z/flag_n set from that value; -> DONE.
  - cond true, ld=0, opc=111 -> DONE with res_err=1; no write; flags unchanged.
  - otherwise -> EXEC; register alu_m=R[rd], alu_n=R[rs], alu_c=cin, alu_opc=opc.
- EXEC: instr_ready=0. ALU ports held stable. At end of cycle: R[rd] <= alu_f, flag_z <= alu_zer, flag_n <= alu_neg; -> DONE.
- DONE: res_valid=1 for exactly one cycle with res_data/res_skip/res_err; -> IDLE.
- ld takes priority over opc: an ld with opc=111 is a valid load.
- rd=rs is legal; both operands read the same pre-write value.
- cin is ignored by the ALU for opc≠000 but is still driven onto alu_c.
- Arithmetic wraps mod 2^16; the sequencer never inspects overflow.

## Timing
- Reset values:
  - state=IDLE; R0–R3=0; flag_z=0, flag_n=0.
  - alu_m=alu_n=0, alu_c=0, alu_opc=000.
  - res_valid=res_skip=res_err=0, res_data=0.
  - instr_ready=1 in the first cycle after rst deasserts.
- ALU op latency: handshake edge T; EXEC during cycle T+1; register write at edge T+2; res_valid high in cycle T+2; instr_ready high again in cycle T+3.
- Load, skip and error skip EXEC: res_valid in cycle T+1, instr_ready in cycle T+2.
- Throughput: one ALU op per 3 cycles, one load/skip per 2 cycles.
- instr_valid while instr_ready=0 is ignored; no buffering.
- alu_* outputs hold their last values outside EXEC.
- rst in any state (including mid-EXEC) aborts: no write-back, no res_valid, all registers reset next edge.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_INV);
  - cond encodings;
  - state enum {IDLE, EXEC, DONE};
  - instruction field offsets.
- Sub-module regfile4x16: 2 async read ports, 1 sync write port, sync reset.
- The ALU is instantiated beside the sequencer at the next level up, not inside it.

## Test plan
- Load imm5=5 to R0, load imm5=11101 to R1 -> R0=0x0005, R1=0xFFFD, flag_n=1 after the second load, res_valid pulses at cycle T+1.
- opc000 rd=R0 rs=R1 cin=1 -> alu_m=5, alu_n=0xFFFD, alu_c=1 in EXEC; R0=0x0003; flags Z=0, N=0; res_valid at T+2.
- opc010 (max) with R2=5, R3=0xFFFD, rd=R2 -> R2=0x0005; rd=R3 rs=R2 -> R3=0x0005.
- Set Z=0, issue cond=01 add -> res_skip=1, R[rd] unchanged, flags unchanged; then cond=11 add executes normally.
- opc111 with ld=0 -> res_err=1, no register or flag change; the next instruction is accepted in cycle T+2.
- Assert rst during EXEC of 3·M on R0=0x0007 -> no write of 0x0015, no res_valid; all R=0 and instr_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: ALU opcode values,
// condition encodings, sequencer state type, instruction field positions
// and small decode helpers.
package alu_seq_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_ADD   = 3'b000;  // M + N + cin
    localparam logic [2:0] OP_ADDSH = 3'b001;  // M + (N >>> 1)
    localparam logic [2:0] OP_MAX   = 3'b010;  // signed max(M, N)
    localparam logic [2:0] OP_MUL3  = 3'b011;  // 3 * M
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_NOT   = 3'b110;
    localparam logic [2:0] OP_INV   = 3'b111;

    // Condition encodings
    localparam logic [1:0] COND_AL = 2'b00;  // always
    localparam logic [1:0] COND_Z  = 2'b01;  // Z = 1
    localparam logic [1:0] COND_N  = 2'b10;  // N = 1
    localparam logic [1:0] COND_NZ = 2'b11;  // Z = 0

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // Instruction field offsets
    localparam int unsigned F_OPC_HI  = 15;
    localparam int unsigned F_OPC_LO  = 13;
    localparam int unsigned F_RD_HI   = 12;
    localparam int unsigned F_RD_LO   = 11;
    localparam int unsigned F_RS_HI   = 10;
    localparam int unsigned F_RS_LO   = 9;
    localparam int unsigned F_CIN     = 8;
    localparam int unsigned F_COND_HI = 7;
    localparam int unsigned F_COND_LO = 6;
    localparam int unsigned F_LD      = 5;
    localparam int unsigned F_IMM_HI  = 4;
    localparam int unsigned F_IMM_LO  = 0;

    function automatic logic cond_met(input logic [1:0] cond,
                                      input logic       z,
                                      input logic       n);
        logic ok;
        ok = 1'b1;
        case (cond)
            COND_AL: ok = 1'b1;
            COND_Z:  ok = z;
            COND_N:  ok = n;
            COND_NZ: ok = ~z;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [15:0] sext_imm5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_regfile.sv
// regfile4x16
// Four 16-bit registers with two asynchronous read ports and one
// synchronous write port. Synchronous active-high reset clears all entries.
// Ports:
//   i_clk, i_rst           clock, synchronous reset
//   i_raddr_a/o_rdata_a    read port A
//   i_raddr_b/o_rdata_b    read port B
//   i_we, i_waddr, i_wdata write port
module regfile4x16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_raddr_a,
    output logic [15:0] o_rdata_a,
    input  logic [1:0]  i_raddr_b,
    output logic [15:0] o_rdata_b,
    input  logic        i_we,
    input  logic [1:0]  i_waddr,
    input  logic [15:0] i_wdata
);

    logic [15:0] r_mem [4];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command-side initiator for the 16-bit combinational ALU. Accepts one
// instruction per valid/ready handshake, drives the ALU operand/opcode ports
// from a 4x16 register file, writes the ALU result back and maintains the
// Z/N flags. Loads, skipped conditions and invalid opcodes complete without
// an ALU cycle.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   instr_valid/instr_ready/instr   instruction handshake
//   alu_m/alu_n/alu_c/alu_opc       ALU operand and opcode drive (held outside EXEC)
//   alu_f/alu_zer/alu_neg           ALU result and flags
//   res_valid/res_data/res_skip/res_err  one-cycle completion report
//   flag_z/flag_n                   architectural flags
module alu_cmd_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_m,
    output logic [15:0] alu_n,
    output logic        alu_c,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_f,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_skip,
    output logic        res_err,
    output logic        flag_z,
    output logic        flag_n
);

    seq_state_t  r_state;
    logic        r_instr_ready;
    logic [15:0] r_alu_m;
    logic [15:0] r_alu_n;
    logic        r_alu_c;
    logic [2:0]  r_alu_opc;
    logic [1:0]  r_rd;
    logic        r_res_valid;
    logic [15:0] r_res_data;
    logic        r_res_skip;
    logic        r_res_err;
    logic        r_flag_z;
    logic        r_flag_n;

    logic [2:0]  w_opc;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic        w_cin;
    logic [1:0]  w_cond;
    logic        w_ld;
    logic [15:0] w_ld_val;
    logic        w_handshake;
    logic        w_cond_ok;
    logic [15:0] w_rdata_m;
    logic [15:0] w_rdata_n;
    logic        w_we;
    logic [1:0]  w_waddr;
    logic [15:0] w_wdata;

    assign w_opc       = instr[F_OPC_HI:F_OPC_LO];
    assign w_rd        = instr[F_RD_HI:F_RD_LO];
    assign w_rs        = instr[F_RS_HI:F_RS_LO];
    assign w_cin       = instr[F_CIN];
    assign w_cond      = instr[F_COND_HI:F_COND_LO];
    assign w_ld        = instr[F_LD];
    assign w_ld_val    = sext_imm5(instr[F_IMM_HI:F_IMM_LO]);
    assign w_handshake = instr_valid && (r_state == IDLE);
    assign w_cond_ok   = cond_met(w_cond, r_flag_z, r_flag_n);

    regfile4x16 u_rf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_raddr_a (w_rd),
        .o_rdata_a (w_rdata_m),
        .i_raddr_b (w_rs),
        .o_rdata_b (w_rdata_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata)
    );

    // Single write port shared by immediate loads (at the handshake edge,
    // addressed from the live instruction) and ALU write-back (end of EXEC,
    // addressed from the latched rd).
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_rd;
        w_wdata = w_ld_val;
        if (w_handshake && w_cond_ok && w_ld) begin
            w_we = 1'b1;
        end else if (r_state == EXEC) begin
            w_we    = 1'b1;
            w_waddr = r_rd;
            w_wdata = alu_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_instr_ready <= 1'b1;
            r_alu_m       <= '0;
            r_alu_n       <= '0;
            r_alu_c       <= 1'b0;
            r_alu_opc     <= OP_ADD;
            r_rd          <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_skip    <= 1'b0;
            r_res_err     <= 1'b0;
            r_flag_z      <= 1'b0;
            r_flag_n      <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_res_skip  <= 1'b0;
            r_res_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_instr_ready <= 1'b0;
                        if (!w_cond_ok) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                            r_res_skip  <= 1'b1;
                            r_res_data  <= '0;
                        end else if (w_ld) begin
                            // ld wins over opc, so opc=111 with ld=1 is a load
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_ld_val;
                            r_flag_z    <= (w_ld_val == '0);
                            r_flag_n    <= w_ld_val[15];
                        end else if (w_opc == OP_INV) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_data  <= '0;
                        end else begin
                            r_state   <= EXEC;
                            r_alu_m   <= w_rdata_m;
                            r_alu_n   <= w_rdata_n;
                            r_alu_c   <= w_cin;
                            r_alu_opc <= w_opc;
                            r_rd      <= w_rd;
                        end
                    end
                end
                EXEC: begin
                    r_state     <= DONE;
                    r_res_valid <= 1'b1;
                    r_res_data  <= alu_f;
                    r_flag_z    <= alu_zer;
                    r_flag_n    <= alu_neg;
                end
                DONE: begin
                    r_state       <= IDLE;
                    r_instr_ready <= 1'b1;
                end
                default: begin
                    r_state       <= IDLE;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign alu_m       = r_alu_m;
    assign alu_n       = r_alu_n;
    assign alu_c       = r_alu_c;
    assign alu_opc     = r_alu_opc;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_skip    = r_res_skip;
    assign res_err     = r_res_err;
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with a behavioural 16-bit ALU
// connected beside it. Expected values are hand-computed constants.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_m;
    logic [15:0] alu_n;
    logic        alu_c;
    logic [2:0]  alu_opc;
    logic [15:0] alu_f;
    logic        alu_zer;
    logic        alu_neg;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_skip;
    logic        res_err;
    logic        flag_z;
    logic        flag_n;

    int n_cmp = 0;
    int n_err = 0;

    // results of the most recent run()
    int          lv, lr, npulse;
    logic [15:0] got_d;
    logic        got_sk, got_er;
    logic [15:0] ex_m, ex_n;
    logic        ex_c;
    logic [2:0]  ex_opc;

    alu_cmd_sequencer u_dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_m       (alu_m),
        .alu_n       (alu_n),
        .alu_c       (alu_c),
        .alu_opc     (alu_opc),
        .alu_f       (alu_f),
        .alu_zer     (alu_zer),
        .alu_neg     (alu_neg),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_skip    (res_skip),
        .res_err     (res_err),
        .flag_z      (flag_z),
        .flag_n      (flag_n)
    );

    // Behavioural ALU
    always_comb begin
        alu_f = '0;
        case (alu_opc)
            3'd0: alu_f = alu_m + alu_n + {15'd0, alu_c};
            3'd1: alu_f = alu_m + 16'($signed(alu_n) >>> 1);
            3'd2: alu_f = ($signed(alu_m) > $signed(alu_n)) ? alu_m : alu_n;
            3'd3: alu_f = alu_m + alu_m + alu_m;
            3'd4: alu_f = alu_m & alu_n;
            3'd5: alu_f = alu_m | alu_n;
            3'd6: alu_f = ~alu_m;
            default: alu_f = '0;
        endcase
        alu_zer = (alu_f == '0);
        alu_neg = alu_f[15];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] opc, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic cin,
                                       input logic [1:0] cond, input logic ld,
                                       input logic [4:0] imm);
        return {opc, rd, rs, cin, cond, ld, imm};
    endfunction

    // Issue one instruction, then sample #1 after each of the next 5 edges.
    // Sample k=1 is the cycle right after the handshake edge.
    task automatic run(input logic [15:0] ins);
        int w;
        lv = 0; lr = 0; npulse = 0;
        got_d = '0; got_sk = 1'b0; got_er = 1'b0;
        ex_m = '0; ex_n = '0; ex_c = 1'b0; ex_opc = '0;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) begin
                ex_m = alu_m; ex_n = alu_n; ex_c = alu_c; ex_opc = alu_opc;
            end
            if (res_valid) begin
                npulse++;
                if (lv == 0) begin
                    lv = k; got_d = res_data; got_sk = res_skip; got_er = res_err;
                end
            end
            if (instr_ready && lr == 0) lr = k;
            if (k < 5) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_op(input string t, input logic [15:0] ins, input int elv,
                         input logic [15:0] ed, input logic esk, input logic eer,
                         input logic ez, input logic en);
        run(ins);
        chk({t, ".lat_valid"}, lv, elv);
        chk({t, ".lat_ready"}, lr, elv + 1);
        chk({t, ".pulses"}, npulse, 1);
        chk({t, ".data"}, {16'd0, got_d}, {16'd0, ed});
        chk({t, ".skip"}, {31'd0, got_sk}, {31'd0, esk});
        chk({t, ".err"}, {31'd0, got_er}, {31'd0, eer});
        chk({t, ".flag_z"}, {31'd0, flag_z}, {31'd0, ez});
        chk({t, ".flag_n"}, {31'd0, flag_n}, {31'd0, en});
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst.ready", {31'd0, instr_ready}, 32'd1);
        chk("rst.res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst.flags", {30'd0, flag_z, flag_n}, 32'd0);
        chk("rst.alu_m", {16'd0, alu_m}, 32'd0);
        chk("rst.alu_opc", {29'd0, alu_opc}, 32'd0);
        chk("rst.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'd0);
        chk("rst.R3", {16'd0, u_dut.u_rf.r_mem[3]}, 32'd0);

        // loads
        do_op("ld_r0", mk(3'd0, 2'd0, 2'd0, 1'b0, 2'b00, 1'b1, 5'd5), 1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ld_r0.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'h0005);
        do_op("ld_r1", mk(3'd0, 2'd1, 2'd0, 1'b0, 2'b00, 1'b1, 5'b11101), 1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ld_r1.R1", {16'd0, u_dut.u_rf.r_mem[1]}, 32'hFFFD);

        // add with carry: 5 + 0xFFFD + 1 = 0x0003
        do_op("add", mk(3'd0, 2'd0, 2'd1, 1'b1, 2'b00, 1'b0, 5'd0), 2, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add.alu_m", {16'd0, ex_m}, 32'h0005);
        chk("add.alu_n", {16'd0, ex_n}, 32'hFFFD);
        chk("add.alu_c", {31'd0, ex_c}, 32'd1);
        chk("add.alu_opc", {29'd0, ex_opc}, 32'd0);
        chk("add.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'h0003);

        // signed max
        do_op("ld_r2", mk(3'd0, 2'd2, 2'd0, 1'b0, 2'b00, 1'b1, 5'd5), 1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("ld_r3", mk(3'd0, 2'd3, 2'd0, 1'b0, 2'b00, 1'b1, 5'b11101), 1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("max23", mk(3'd2, 2'd2, 2'd3, 1'b0, 2'b00, 1'b0, 5'd0), 2, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("max23.R2", {16'd0, u_dut.u_rf.r_mem[2]}, 32'h0005);
        do_op("max32", mk(3'd2, 2'd3, 2'd2, 1'b0, 2'b00, 1'b0, 5'd0), 2, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("max32.R3", {16'd0, u_dut.u_rf.r_mem[3]}, 32'h0005);

        // Z=0: cond=01 skips, cond=11 executes (3 + 0xFFFD = 0 -> Z=1)
        do_op("skipZ", mk(3'd0, 2'd0, 2'd1, 1'b0, 2'b01, 1'b0, 5'd0), 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("skipZ.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'h0003);
        do_op("addNZ", mk(3'd0, 2'd0, 2'd1, 1'b0, 2'b11, 1'b0, 5'd0), 2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("addNZ.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'h0000);

        // Z=1 now: cond=01 executes AND 0xFFFD & 5 = 5
        do_op("andZ", mk(3'd4, 2'd1, 2'd2, 1'b0, 2'b01, 1'b0, 5'd0), 2, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("andZ.R1", {16'd0, u_dut.u_rf.r_mem[1]}, 32'h0005);

        // NOT then invalid opcode: flags stay Z=0 N=1
        do_op("not2", mk(3'd6, 2'd2, 2'd0, 1'b0, 2'b00, 1'b0, 5'd0), 2, 16'hFFFA, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("inv", mk(3'd7, 2'd2, 2'd1, 1'b0, 2'b00, 1'b0, 5'd0), 1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("inv.R2", {16'd0, u_dut.u_rf.r_mem[2]}, 32'hFFFA);
        chk("inv.R1", {16'd0, u_dut.u_rf.r_mem[1]}, 32'h0005);

        // ld with opc=111 is a valid load of 0
        do_op("ld_inv", mk(3'd7, 2'd1, 2'd0, 1'b0, 2'b00, 1'b1, 5'd0), 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ld_inv.R1", {16'd0, u_dut.u_rf.r_mem[1]}, 32'h0000);

        // rd=rs: 0xFFFA + 0xFFFA = 0xFFF4
        do_op("same", mk(3'd0, 2'd2, 2'd2, 1'b0, 2'b00, 1'b0, 5'd0), 2, 16'hFFF4, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("same.alu_m", {16'd0, ex_m}, 32'hFFFA);
        chk("same.alu_n", {16'd0, ex_n}, 32'hFFFA);

        // M + (N>>>1): 5 + 0xFFFA = 0xFFFF; cin still driven
        do_op("addsh", mk(3'd1, 2'd3, 2'd2, 1'b1, 2'b00, 1'b0, 5'd0), 2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("addsh.alu_c", {31'd0, ex_c}, 32'd1);
        chk("addsh.alu_opc", {29'd0, ex_opc}, 32'd1);

        // N=1: cond=10 load executes; ALU ports hold their last values
        do_op("ldN", mk(3'd0, 2'd0, 2'd0, 1'b0, 2'b10, 1'b1, 5'd7), 1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold.alu_m", {16'd0, alu_m}, 32'h0005);
        chk("hold.alu_opc", {29'd0, alu_opc}, 32'd1);
        // N=0: cond=10 skips
        do_op("skipN", mk(3'd0, 2'd1, 2'd0, 1'b0, 2'b10, 1'b1, 5'd9), 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("skipN.R1", {16'd0, u_dut.u_rf.r_mem[1]}, 32'h0000);

        // reset during EXEC of 3*R0 (R0=7): no write of 0x0015, no res_valid
        @(negedge clk);
        instr       = mk(3'd3, 2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 5'd0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("rexec.alu_opc", {29'd0, alu_opc}, 32'd3);
        chk("rexec.alu_m", {16'd0, alu_m}, 32'h0007);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        chk("rexec.ready", {31'd0, instr_ready}, 32'd1);
        chk("rexec.alu_m0", {16'd0, alu_m}, 32'd0);
        chk("rexec.flags", {30'd0, flag_z, flag_n}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            if (res_valid) cnt++;
            @(posedge clk);
            #1;
        end
        chk("rexec.no_valid", cnt, 0);
        chk("rexec.R0", {16'd0, u_dut.u_rf.r_mem[0]}, 32'd0);
        chk("rexec.R2", {16'd0, u_dut.u_rf.r_mem[2]}, 32'd0);
        chk("rexec.R3", {16'd0, u_dut.u_rf.r_mem[3]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
